mem_burst_ctrl: RTL and testbench

Burst access controller that sits directly upstream of the single-port data memory and is its only master. It accepts burst read/write commands over a valid/ready handshake, streams write beats into the memory, and issues memory reads. It returns read data over a back-pressurable response channel, hiding the memory's fixed 1-cycle registered read latency behind a 2-entry response FIFO.

---
 rtl/mem_burst_ctrl.sv | 129 ++++++++++++
 tb/tb_mem_burst_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: burst read/write front end and sole master of a single-port memory with 1-cycle read latency.
// Latency: first memory access the cycle after command accept; read beat reaches o_rsp_* two cycles after its o_mem_rd_en.
// Backpressure: writes stall on i_wd_valid; read issue is credit-limited by the 2-entry response FIFO so no beat is dropped.
module mem_burst_ctrl #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_write,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [LEN_W-1:0]  i_req_len,
   input  logic              i_wd_valid,
   output logic              o_wd_ready,
   input  logic [DATA_W-1:0] i_wd_data,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [DATA_W-1:0] o_rsp_data,
   output logic              o_rsp_last,
   output logic              o_busy,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_rd_en,
   output logic              o_mem_wr_en,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_cur_addr;
   logic [LEN_W-1:0]  r_beats_left;
   logic              r_inflight;
   logic              r_inflight_last;
   logic [DATA_W:0]   r_fifo [2];      // {last, data}
   logic              r_wr_ptr;
   logic              r_rd_ptr;
   logic [1:0]        r_fifo_count;

   logic              w_accept;
   logic              w_wr_beat;
   logic              w_pop;
   logic              w_issue;
   logic              w_final;
   logic [2:0]        w_occupancy;     // FIFO entries plus in-flight read, after this cycle's pop
   logic [DATA_W:0]   w_head;

   // Handshakes, read credit and memory-side drive
   always_comb begin
      w_final     = (r_beats_left == '0);
      w_accept    = (r_state == ST_IDLE) && i_req_valid;
      w_wr_beat   = (r_state == ST_WRITE) && i_wd_valid;
      w_pop       = o_rsp_valid && i_rsp_ready;
      w_occupancy = {1'b0, r_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
      w_issue     = (r_state == ST_READ) && (w_occupancy < 3'd2);
      w_head      = r_fifo[r_rd_ptr];

      o_req_ready = i_rst_n && (r_state == ST_IDLE);
      o_wd_ready  = (r_state == ST_WRITE);
      o_mem_wr_en = w_wr_beat;
      o_mem_rd_en = w_issue;
      o_mem_addr  = (w_wr_beat || w_issue) ? r_cur_addr : '0;
      o_mem_wdata = w_wr_beat ? i_wd_data : '0;
      o_rsp_valid = (r_fifo_count != 2'd0);
      o_rsp_data  = o_rsp_valid ? w_head[DATA_W-1:0] : '0;
      o_rsp_last  = o_rsp_valid && w_head[DATA_W];
      o_busy      = (r_state != ST_IDLE) || (r_fifo_count != 2'd0) || r_inflight;
   end

   // Burst sequencing: address/beat counters, state, in-flight read tracking
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state         <= ST_IDLE;
         r_cur_addr      <= '0;
         r_beats_left    <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_cur_addr   <= i_req_addr;
                  r_beats_left <= i_req_len;
                  r_state      <= i_req_write ? ST_WRITE : ST_READ;
               end
            end
            ST_WRITE: begin
               if (w_wr_beat) begin
                  r_cur_addr   <= r_cur_addr + ADDR_W'(1);
                  r_beats_left <= r_beats_left - LEN_W'(1);
                  if (w_final) r_state <= ST_IDLE;
               end
            end
            ST_READ: begin
               if (w_issue) begin
                  r_cur_addr      <= r_cur_addr + ADDR_W'(1);
                  r_beats_left    <= r_beats_left - LEN_W'(1);
                  r_inflight_last <= w_final;
                  if (w_final) r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Response FIFO: capture memory data one cycle after issue, pop on consumer handshake
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_fifo[0]    <= '0;
         r_fifo[1]    <= '0;
         r_wr_ptr     <= 1'b0;
         r_rd_ptr     <= 1'b0;
         r_fifo_count <= 2'd0;
      end else begin
         if (r_inflight) begin
            r_fifo[r_wr_ptr] <= {r_inflight_last, i_mem_rdata};
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         r_fifo_count <= r_fifo_count + {1'b0, r_inflight} - {1'b0, w_pop};
      end
   end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: directed bench for mem_burst_ctrl with a memory model and a transaction-level scoreboard.
// Latency: not applicable (bench).
// Backpressure: bench drives i_rsp_ready patterns directly.
module tb_mem_burst_ctrl;

   typedef struct packed {
      logic        wr;
      logic [15:0] addr;
      logic [31:0] data;
   } acc_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
   logic [15:0] req_addr = '0;
   logic [3:0]  req_len = '0;
   logic        wd_valid = 1'b0, wd_ready;
   logic [31:0] wd_data = '0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_last, busy;
   logic [31:0] rsp_data;
   logic [15:0] mem_addr;
   logic        mem_rd_en, mem_wr_en;
   logic [31:0] mem_wdata, mem_rdata = '0;

   mem_burst_ctrl #(.ADDR_W(16), .DATA_W(32), .LEN_W(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
      .i_req_addr(req_addr), .i_req_len(req_len),
      .i_wd_valid(wd_valid), .o_wd_ready(wd_ready), .i_wd_data(wd_data),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data), .o_rsp_last(rsp_last),
      .o_busy(busy), .o_mem_addr(mem_addr), .o_mem_rd_en(mem_rd_en), .o_mem_wr_en(mem_wr_en),
      .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int ncyc  = 0;

   always @(posedge clk) ncyc <= ncyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Memory with a registered 1-cycle read
   logic [31:0] mem [int];
   always @(posedge clk) begin
      if (mem_wr_en) mem[int'(mem_addr)] = mem_wdata;
      if (mem_rd_en) mem_rdata <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 32'h0;
   end

   // Behavioural model: expected memory accesses and expected response beats, in order
   logic [31:0] shadow [int];
   acc_t        exp_acc[$];
   logic [32:0] exp_rsp[$];
   acc_t        acc_log[$];
   logic [32:0] rsp_log[$];
   int          rsp_cyc[$];
   logic [31:0] wdata_q[$];
   logic        prev_hold = 1'b0;
   logic [32:0] prev_rsp = '0;

   // Per-cycle comparison of DUT outputs against the model
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_hold = 1'b0;
      end else begin
         if (mem_rd_en || mem_wr_en) begin
            check("mem_single_enable", {mem_rd_en, mem_wr_en} == 2'b11, 1'b0);
            if (exp_acc.size() == 0) begin
               check("mem_unexpected_access", 1'b1, 1'b0);
            end else begin
               acc_t e;
               e = exp_acc.pop_front();
               check("mem_dir", mem_wr_en, e.wr);
               check("mem_addr", mem_addr, e.addr);
               if (e.wr) check("mem_wdata", mem_wdata, e.data);
            end
            acc_log.push_back('{wr: mem_wr_en, addr: mem_addr, data: mem_wdata});
         end else begin
            check("mem_addr_idle", mem_addr, 16'h0);
            check("mem_wdata_idle", mem_wdata, 32'h0);
         end
         if (mem_wr_en) check("wr_en_needs_wd_valid", wd_valid, 1'b1);
         if (prev_hold) begin
            check("rsp_hold_valid", rsp_valid, 1'b1);
            check("rsp_hold_data", {rsp_last, rsp_data}, prev_rsp);
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_rsp.size() == 0) check("rsp_unexpected", 1'b1, 1'b0);
            else check("rsp_beat", {rsp_last, rsp_data}, exp_rsp.pop_front());
            rsp_log.push_back({rsp_last, rsp_data});
            rsp_cyc.push_back(ncyc);
         end
         prev_hold = rsp_valid && !rsp_ready;
         prev_rsp  = {rsp_last, rsp_data};
      end
   end

   task automatic send_cmd(input logic w, input logic [15:0] a, input logic [3:0] len, output int waited);
      req_valid = 1'b1; req_write = w; req_addr = a; req_len = len;
      waited = 0;
      do begin @(negedge clk); waited++; end while (!req_ready && waited < 50);
      if (!req_ready) check("cmd_accept_timeout", 1'b0, 1'b1);
      for (int i = 0; i <= int'(len); i++) begin
         acc_t e;
         int   ad;
         ad = int'(a + 16'(i));
         e.wr = w; e.addr = 16'(ad);
         if (w) begin
            e.data = wdata_q[i];
            shadow[ad] = wdata_q[i];
         end else begin
            e.data = 32'h0;
            exp_rsp.push_back({i == int'(len), shadow.exists(ad) ? shadow[ad] : 32'h0});
         end
         exp_acc.push_back(e);
      end
      @(posedge clk); #1;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
   endtask

   task automatic send_wbeats(input int n, input bit stall);
      for (int i = 0; i < n; i++) begin
         int t;
         t = 0;
         wd_valid = 1'b1; wd_data = wdata_q[i];
         do begin @(negedge clk); t++; end while (!wd_ready && t < 50);
         if (!wd_ready) check("wd_accept_timeout", 1'b0, 1'b1);
         @(posedge clk); #1;
         wd_valid = 1'b0; wd_data = '0;
         if (stall && i < n - 1) begin @(posedge clk); #1; end
      end
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      do begin @(negedge clk); t++; end
      while ((busy || exp_acc.size() != 0 || exp_rsp.size() != 0) && t < 200);
      check(name, {busy, exp_acc.size() != 0, exp_rsp.size() != 0}, 3'b000);
      @(posedge clk); #1;
   endtask

   task automatic clear_logs();
      acc_log.delete(); rsp_log.delete(); rsp_cyc.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w, c0, n;
      logic [31:0] lit_a [4];
      lit_a[0] = 32'hA0; lit_a[1] = 32'hA1; lit_a[2] = 32'hA2; lit_a[3] = 32'hA3;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_wd_ready", wd_ready, 1'b0);
      check("rst_mem_en", {mem_rd_en, mem_wr_en}, 2'b00);
      check("rst_mem_addr", mem_addr, 16'h0);
      check("rst_rsp", {rsp_valid, rsp_last, rsp_data}, 34'h0);
      check("rst_busy", busy, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_req_ready", req_ready, 1'b1);

      // Write then read, 4 beats at 0x0010
      wdata_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      send_cmd(1'b1, 16'h0010, 4'd3, w);
      c0 = ncyc;
      send_wbeats(4, 1'b0);
      check("wr4_cycles", ncyc - c0, 4);
      wait_idle("wr4_idle");
      rsp_ready = 1'b1;
      clear_logs();
      send_cmd(1'b0, 16'h0010, 4'd3, w);
      n = 1;
      while (n < 20) begin @(negedge clk); if (rsp_valid) break; n++; end
      check("rd4_first_latency", n, 3);
      wait_idle("rd4_idle");
      check("rd4_count", rsp_log.size(), 4);
      for (int i = 0; i < 4 && i < rsp_log.size(); i++)
         check("rd4_literal", rsp_log[i], {i == 3, lit_a[i]});
      if (rsp_cyc.size() == 4) check("rd4_back_to_back", rsp_cyc[3] - rsp_cyc[0], 3);

      // Write with wd_valid toggling, 2 beats at 0x0005
      clear_logs();
      wdata_q = '{32'h11, 32'h22};
      send_cmd(1'b1, 16'h0005, 4'd1, w);
      send_wbeats(2, 1'b1);
      @(negedge clk);
      check("wstall_idle_after", req_ready, 1'b1);
      check("wstall_count", acc_log.size(), 2);
      if (acc_log.size() == 2) begin
         check("wstall_a0", {acc_log[0].wr, acc_log[0].addr}, {1'b1, 16'h0005});
         check("wstall_a1", {acc_log[1].wr, acc_log[1].addr}, {1'b1, 16'h0006});
      end
      @(posedge clk); #1;

      // Backpressure: 8-beat read with the consumer stalled for 10 cycles
      wdata_q.delete();
      for (int i = 0; i < 8; i++) wdata_q.push_back(32'hB000 + 32'(i));
      send_cmd(1'b1, 16'h0100, 4'd7, w);
      c0 = ncyc;
      send_wbeats(8, 1'b0);
      check("wr8_cycles", ncyc - c0, 8);
      wait_idle("wr8_idle");
      rsp_ready = 1'b0;
      clear_logs();
      send_cmd(1'b0, 16'h0100, 4'd7, w);
      n = 0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); if (mem_rd_en) n++; end
      check("bp_rd_pulses", n, 2);
      check("bp_rsp_valid", rsp_valid, 1'b1);
      @(posedge clk); #1; rsp_ready = 1'b1;
      wait_idle("bp_idle");
      check("bp_count", rsp_log.size(), 8);
      for (int i = 0; i < 8 && i < rsp_log.size(); i++)
         check("bp_literal", rsp_log[i], {i == 7, 32'hB000 + 32'(i)});

      // Address wrap
      clear_logs();
      send_cmd(1'b0, 16'hFFFF, 4'd2, w);
      wait_idle("wrap_idle");
      check("wrap_count", acc_log.size(), 3);
      if (acc_log.size() == 3) begin
         check("wrap_a0", acc_log[0].addr, 16'hFFFF);
         check("wrap_a1", acc_log[1].addr, 16'h0000);
         check("wrap_a2", acc_log[2].addr, 16'h0001);
      end

      // Read, then a write accepted while read data still sits in the FIFO
      rsp_ready = 1'b0;
      clear_logs();
      send_cmd(1'b0, 16'h0010, 4'd1, w);
      wdata_q = '{32'hC0};
      send_cmd(1'b1, 16'h0200, 4'd0, w);
      check("b2b_write_wait", w, 3);
      send_wbeats(1, 1'b0);
      check("b2b_no_rsp_yet", rsp_log.size(), 0);
      check("b2b_fifo_full", rsp_valid, 1'b1);
      rsp_ready = 1'b1;
      wait_idle("b2b_idle");
      check("b2b_count", rsp_log.size(), 2);
      if (rsp_log.size() == 2) begin
         check("b2b_r0", rsp_log[0], {1'b0, 32'hA0});
         check("b2b_r1", rsp_log[1], {1'b1, 32'hA1});
      end

      // Reset in the middle of an 8-beat read
      send_cmd(1'b0, 16'h0100, 4'd7, w);
      n = 0;
      for (int t = 0; t < 20 && n < 2; t++) begin @(negedge clk); if (mem_rd_en) n++; end
      check("mid_rst_two_issued", n, 2);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_req_ready", req_ready, 1'b0);
      check("mid_rst_wd_ready", wd_ready, 1'b0);
      check("mid_rst_mem", {mem_rd_en, mem_wr_en, mem_addr, mem_wdata}, 50'h0);
      check("mid_rst_rsp", {rsp_valid, rsp_last, rsp_data}, 34'h0);
      check("mid_rst_busy", busy, 1'b0);
      exp_acc.delete(); exp_rsp.delete();
      repeat (3) begin
         @(negedge clk);
         check("mid_rst_no_enable", {mem_rd_en, mem_wr_en}, 2'b00);
      end
      #2 rst_n = 1'b1;
      #1;
      check("post_mid_rst_ready", req_ready, 1'b1);
      check("post_mid_rst_busy", busy, 1'b0);
      @(posedge clk); #1;
      clear_logs();
      send_cmd(1'b0, 16'h0100, 4'd1, w);
      wait_idle("post_rst_read_idle");
      check("post_rst_count", rsp_log.size(), 2);
      if (rsp_log.size() == 2) begin
         check("post_rst_r0", rsp_log[0], {1'b0, 32'hB000});
         check("post_rst_r1", rsp_log[1], {1'b1, 32'hB001});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
